piso_stream_ser: RTL and testbench
==================================

Name: piso_stream_ser

Overview:
- Parametrised parallel-in/serial-out serializer; next generation of the team's fixed 4-bit PISO shift register.
- Adds configurable width, selectable bit order, a valid/ready load handshake, a one-word holding buffer for gapless back-to-back frames, bit-rate strobe and frame status pulses.
- Sits between a parallel producer (register block, FIFO) and a serial line driver (SPI-like TX, LED chain).

Parameters:
- WIDTH, 8, bits per frame (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort; drops current frame and holding buffer.
- shift_en  input  1  bit strobe; one serial bit advances per cycle with shift_en=1.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- sdo  output  1  serial data out; 0 when sdo_valid=0.
- sdo_valid  output  1  sdo carries a frame bit.
- frame_start  output  1  one-cycle pulse: first bit of a frame is on sdo.
- frame_done  output  1  one-cycle pulse: last bit of a frame shifted out (same cycle as that bit's shift_en).
- busy  output  1  state==SHIFT or holding buffer full.

Behaviour:
- Reset (async): state IDLE, shift reg 0, bit_cnt 0, hold empty; sdo=0, sdo_valid=0, frame_start=0, frame_done=0, busy=0, in_ready=0 during reset, 1 from first cycle after release.
- State machine: IDLE, SHIFT. bit_cnt width $clog2(WIDTH), range 0..WIDTH-1.
- Handshake: transfer when in_valid & in_ready. in_ready = !hold_full & !flush. in_data sampled only on transfer.
- IDLE + transfer: shift reg <= in_data, bit_cnt <= 0, next state SHIFT; frame_start pulses the following cycle (first bit on sdo). Latency accept->first bit = 1 cycle.
- SHIFT + transfer: word goes to holding buffer (hold_full <= 1).
- SHIFT, shift_en=1, bit_cnt<WIDTH-1: shift toward output end (left if MSB_FIRST, else right), vacated bit filled with 0, bit_cnt+1.
- SHIFT, shift_en=1, bit_cnt==WIDTH-1 (last bit): frame_done=1 this cycle. Then priority: (a) hold_full -> load shift reg from hold, hold empty, stay SHIFT, bit_cnt 0, frame_start next cycle; (b) else transfer this cycle (bypass) -> load in_data, stay SHIFT, same as (a); (c) else -> IDLE. Cases (a)/(b) give zero idle bits between frames.
- shift_en=0 in SHIFT: all state held; sdo stable.
- shift_en ignored in IDLE.
- sdo = output-end bit of shift reg when SHIFT, else 0. sdo_valid = (state==SHIFT).
- flush=1: next cycle state IDLE, hold empty, bit_cnt 0, shift reg 0; no frame_done for aborted frame; in_ready=0 in flush cycle (flush beats simultaneous in_valid). frame_done is suppressed if flush coincides with last-bit shift.
- Reset mid-frame: immediate return to reset values; partial frame lost.

Decomposition:
- Shared package piso_pkg: state enum (ST_IDLE, ST_SHIFT), bit-order constants MSB_FIRST/LSB_FIRST, function cnt_w(WIDTH) = $clog2(WIDTH).
- No sub-module required; optional hold register piso_hold_buf (1-entry valid/data register) if reused by deserializer work.

Test Plan:
- WIDTH=8, MSB_FIRST=1, shift_en=1 constant, load 0xA5 -> sdo sequence 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; frame_start on bit 1, frame_done on bit 8; then IDLE, sdo=0.
- MSB_FIRST=0, load 0xA5 -> sdo 1,0,1,0,0,1,0,1 reversed order (bit0 first: 1,0,1,0,0,1,0,1 read LSB->MSB); verify against 0x01 -> single 1 on first bit only.
- Back-to-back: load 0xF0 then 0x0F while shifting -> in_ready drops after 2nd accept, 16 contiguous valid bits 11110000 00001111, no gap, two frame_done pulses 8 cycles apart.
- shift_en toggled 1-of-3 cycles, load 0x81 -> each bit held 3 cycles, 24-cycle frame, sdo values unchanged by stalls.
- flush asserted at bit 4 of 0xFF with 0x55 in hold -> next cycle sdo_valid=0, busy=0, no frame_done; subsequent load 0x55 transmits correctly.
- reset_n low at bit 3 -> all outputs 0 asynchronously; after release in_ready=1, next frame 0x3C serialized correctly.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types, bit-order constants and sizing helper for the PISO serializer
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_t;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - single-entry valid/data holding register
module piso_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full    <= 1'b0;
      rd_data <= '0;
    end else if (clr) begin
      full    <= 1'b0;
      rd_data <= '0;
    end else if (wr_en) begin
      full    <= 1'b1;
      rd_data <= wr_data;
    end else if (rd_en) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_stream_ser.sv
// rtl/piso_stream_ser.sv - parametrised parallel-in/serial-out serializer with
// valid/ready load, one-word holding buffer and frame status pulses
module piso_stream_ser
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             shift_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int            CW        = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam bit            SHIFT_LFT = (MSB_FIRST == ORDER_MSB_FIRST);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             rdy_en;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             xfer;
  logic             last_shift;
  logic             hold_wr;
  logic             hold_rd;

  // rdy_en keeps in_ready low while reset is held and until the first clock after release
  assign in_ready   = rdy_en & ~hold_full & ~flush;
  assign xfer       = in_valid & in_ready;
  assign last_shift = (state == ST_SHIFT) & shift_en & (bit_cnt == LAST_BIT);
  assign frame_done = last_shift & ~flush;
  assign sdo_valid  = (state == ST_SHIFT);
  assign sdo        = sdo_valid & (SHIFT_LFT ? shreg[WIDTH-1] : shreg[0]);
  assign busy       = sdo_valid | hold_full;

  assign hold_wr = xfer & (state == ST_SHIFT) & ~last_shift;
  assign hold_rd = last_shift & hold_full & ~flush;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (flush),
    .wr_en   (hold_wr),
    .wr_data (in_data),
    .rd_en   (hold_rd),
    .full    (hold_full),
    .rd_data (hold_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      rdy_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      frame_start <= 1'b0;
      if (flush) begin
        state   <= ST_IDLE;
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (xfer) begin
              shreg       <= in_data;
              bit_cnt     <= '0;
              state       <= ST_SHIFT;
              frame_start <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (last_shift) begin
              // Reload from hold first, else bypass a word accepted this cycle: no idle bit between frames
              if (hold_full) begin
                shreg       <= hold_data;
                bit_cnt     <= '0;
                frame_start <= 1'b1;
              end else if (xfer) begin
                shreg       <= in_data;
                bit_cnt     <= '0;
                frame_start <= 1'b1;
              end else begin
                state   <= ST_IDLE;
                shreg   <= '0;
                bit_cnt <= '0;
              end
            end else if (shift_en) begin
              shreg   <= SHIFT_LFT ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_stream_ser.sv
// tb/tb_piso_stream_ser.sv - bench for piso_stream_ser, MSB-first and LSB-first instances
// driven in lockstep against a word/bit-index reference model
module tb_piso_stream_ser;
  import piso_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         shift_en = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic in_ready_m, sdo_m, sdo_valid_m, frame_start_m, frame_done_m, busy_m;
  logic in_ready_l, sdo_l, sdo_valid_l, frame_start_l, frame_done_l, busy_l;

  piso_stream_ser #(.WIDTH(W), .MSB_FIRST(ORDER_MSB_FIRST)) dut_m (
    .clk(clk), .reset_n(reset_n), .flush(flush), .shift_en(shift_en),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .sdo(sdo_m), .sdo_valid(sdo_valid_m), .frame_start(frame_start_m),
    .frame_done(frame_done_m), .busy(busy_m)
  );

  piso_stream_ser #(.WIDTH(W), .MSB_FIRST(ORDER_LSB_FIRST)) dut_l (
    .clk(clk), .reset_n(reset_n), .flush(flush), .shift_en(shift_en),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .sdo(sdo_l), .sdo_valid(sdo_valid_l), .frame_start(frame_start_l),
    .frame_done(frame_done_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: current word plus index of the bit on the line, and a queue of waiting words
  logic         m_active;
  logic         m_start;
  logic         m_rdy;
  int           m_idx;
  logic [W-1:0] m_cur;
  logic [W-1:0] m_pend[$];
  logic [W-1:0] sent[$];
  logic [W-1:0] rx_m;
  logic [W-1:0] rx_l;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_ready();
    return m_rdy && (m_pend.size() == 0) && !flush;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_start  = 1'b0;
    m_rdy    = 1'b0;
    m_idx    = 0;
    m_cur    = '0;
    m_pend.delete();
    sent.delete();
  endtask

  task automatic check_outputs();
    logic         e_fd, e_sdo_m, e_sdo_l;
    logic [W-1:0] exp_w;
    e_fd    = m_active && shift_en && (m_idx == W-1) && !flush;
    e_sdo_m = m_active ? m_cur[W-1-m_idx] : 1'b0;
    e_sdo_l = m_active ? m_cur[m_idx] : 1'b0;
    chk("in_ready_m", in_ready_m, exp_ready());
    chk("in_ready_l", in_ready_l, exp_ready());
    chk("sdo_m", sdo_m, e_sdo_m);
    chk("sdo_l", sdo_l, e_sdo_l);
    chk("sdo_valid_m", sdo_valid_m, m_active);
    chk("sdo_valid_l", sdo_valid_l, m_active);
    chk("frame_start_m", frame_start_m, m_start);
    chk("frame_start_l", frame_start_l, m_start);
    chk("frame_done_m", frame_done_m, e_fd);
    chk("frame_done_l", frame_done_l, e_fd);
    chk("busy_m", busy_m, m_active || (m_pend.size() != 0));
    chk("busy_l", busy_l, m_active || (m_pend.size() != 0));
    if (shift_en && sdo_valid_m) begin
      rx_m = {rx_m[W-2:0], sdo_m};
      rx_l = {sdo_l, rx_l[W-1:1]};
    end
    if (frame_done_m) begin
      exp_w = (sent.size() != 0) ? sent.pop_front() : 'x;
      chk_word("rx_word_m", rx_m, exp_w);
      chk_word("rx_word_l", rx_l, exp_w);
    end
  endtask

  task automatic model_edge();
    logic xfer;
    if (!reset_n) return;
    xfer    = in_valid && exp_ready();
    m_start = 1'b0;
    if (xfer) sent.push_back(in_data);
    if (flush) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_pend.delete();
      sent.delete();
    end else if (!m_active) begin
      if (xfer) begin
        m_cur    = in_data;
        m_idx    = 0;
        m_active = 1'b1;
        m_start  = 1'b1;
      end
    end else if (shift_en && m_idx == W-1) begin
      if (m_pend.size() != 0) begin
        m_cur   = m_pend.pop_front();
        m_idx   = 0;
        m_start = 1'b1;
      end else if (xfer) begin
        m_cur   = in_data;
        m_idx   = 0;
        m_start = 1'b1;
      end else begin
        m_active = 1'b0;
        m_idx    = 0;
      end
    end else begin
      if (shift_en) m_idx++;
      if (xfer) m_pend.push_back(in_data);
    end
    m_rdy = 1'b1;
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic se, input logic fl);
    in_valid = iv;
    in_data  = d;
    shift_en = se;
    flush    = fl;
    #3;
    check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    shift_en = 1'b0;
    flush    = 1'b0;
    reset_n  = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    rx_m = '0;
    rx_l = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    idle(2);

    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(10);
    cycle(1'b1, 8'h01, 1'b1, 1'b0);
    idle(10);

    // back-to-back frames through the holding buffer
    cycle(1'b1, 8'hF0, 1'b1, 1'b0);
    cycle(1'b1, 8'h0F, 1'b1, 1'b0);
    idle(18);

    // bit strobe on one cycle in three
    for (int i = 0; i < 30; i++) cycle(i == 0, 8'h81, (i % 3) == 2, 1'b0);
    idle(4);

    // flush mid-frame with a word waiting in hold
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    idle(2);
    cycle(1'b1, 8'hAA, 1'b1, 1'b1);
    idle(2);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    idle(10);

    // asynchronous reset mid-frame
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    idle(2);
    do_reset();
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    idle(10);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 40) == 0);
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
